// File: rtl/fibonacci_result_fifo_if.sv
// Result FIFO bus: producer strobe, flush, FWFT consumer handshake and status.
// Ports (slave = FIFO side):
//   in_valid, in_result, flush, out_ready       -> into the FIFO
//   out_valid, out_data, count, full, empty,
//   overflow, drop_cnt                          <- from the FIFO
interface fibonacci_result_fifo_if #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DROP_W = 8
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic [DATA_W-1:0] in_result;
   logic              flush;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;

   modport master (
      output in_valid, in_result, flush, out_ready,
      input  out_valid, out_data, count, full, empty, overflow, drop_cnt
   );

   modport slave (
      input  in_valid, in_result, flush, out_ready,
      output out_valid, out_data, count, full, empty, overflow, drop_cnt
   );
endinterface

// File: rtl/fibonacci_result_fifo.sv
// Captures fibonacci results into a FWFT FIFO; results arriving while full
// (and not freed by a same-cycle pop) are dropped and counted.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - fibonacci_result_fifo_if.slave (push strobe, flush, FWFT pop, status)
module fibonacci_result_fifo #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DROP_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   fibonacci_result_fifo_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
   logic [CNT_W-1:0]  count_q, count_nxt;
   logic              full_q, empty_q, overflow_q, overflow_nxt;
   logic [DROP_W-1:0] drop_q, drop_nxt;
   logic              pop_c, push_c, drop_c;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign pop_c  = !empty_q && bus.out_ready;
   assign push_c = bus.in_valid && (!full_q || pop_c);
   assign drop_c = bus.in_valid && full_q && !pop_c;

   // Next-state for pointers, occupancy and drop statistics.
   always_comb begin
      rd_ptr_nxt   = rd_ptr;
      wr_ptr_nxt   = wr_ptr;
      count_nxt    = count_q;
      overflow_nxt = overflow_q;
      drop_nxt     = drop_q;
      if (bus.flush) begin
         rd_ptr_nxt = '0;
         wr_ptr_nxt = '0;
         count_nxt  = '0;
      end else begin
         if (push_c) wr_ptr_nxt = wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
         if (push_c && !pop_c)      count_nxt = count_q + CNT_W'(1);
         else if (pop_c && !push_c) count_nxt = count_q - CNT_W'(1);
         if (drop_c) begin
            overflow_nxt = 1'b1;
            if (drop_q != '1) drop_nxt = drop_q + DROP_W'(1);
         end
      end
   end

   // State registers; full/empty are registered from the next occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         rd_ptr     <= rd_ptr_nxt;
         wr_ptr     <= wr_ptr_nxt;
         count_q    <= count_nxt;
         full_q     <= (count_nxt == CNT_W'(DEPTH));
         empty_q    <= (count_nxt == '0);
         overflow_q <= overflow_nxt;
         drop_q     <= drop_nxt;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (!rst && !bus.flush && push_c) mem[wr_ptr] <= bus.in_result;
   end

   assign bus.out_valid = !empty_q;
   // Forced to zero while empty so the post-reset value is defined.
   assign bus.out_data  = empty_q ? '0 : mem[rd_ptr];
   assign bus.count     = count_q;
   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.overflow  = overflow_q;
   assign bus.drop_cnt  = drop_q;
endmodule
